cdc_fifo_read_state: RTL and testbench

- Read-domain pointer and flag logic for the dual-clock gray-pointer FIFO. It is the read-side counterpart of the write-side pointer logic.
- Synchronizes the incoming write pointer (gray) into the read clock domain and derives empty and occupancy from it.
- Drives the RAM read address and returns its own pointer in gray code to the write domain.
- Holds one word in a first-word-fall-through output register with a valid/ready handshake.

---
 rtl/cdc_fifo_pkg.sv | 24 ++
 rtl/cdc_sync_bus.sv | 39 +++
 rtl/cdc_fifo_read_state.sv | 91 +++++++++
 tb/tb_cdc_fifo_read_state.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for the dual-clock gray-pointer FIFO: default widths
// and binary/gray conversion helpers used by both pointer domains.
package cdc_fifo_pkg;

    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 4;
    localparam int unsigned DEFAULT_DATA_WIDTH    = 8;
    localparam int unsigned DEFAULT_SYNC_STAGES   = 2;

    // Binary to reflected gray code.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: bit i is the XOR of all gray bits at or above i.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Plain multi-flop synchronizer for a gray-coded bus. No logic between
// stages; asynchronous reset clears every stage to zero.
module cdc_sync_bus #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // Each stage takes the previous one; stage 0 takes the async input.
    always_comb begin
        stage_d[0] = d;
        for (int unsigned i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Synchronizer flop chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/cdc_fifo_read_state.sv
// Read-domain pointer/flag logic for the dual-clock gray-pointer FIFO.
// Synchronizes the writer's gray pointer, derives empty/occupancy, drives
// the RAM read address, returns a registered gray read pointer, and holds
// the head word in a first-word-fall-through output register.
module cdc_fifo_read_state
    import cdc_fifo_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] write_address_gray,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [ADDRESS_WIDTH-1:0] read_address_gray,
    output logic                     empty,
    output logic [ADDRESS_WIDTH-1:0] ram_count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data
);

    logic [ADDRESS_WIDTH-1:0] wsync_gray;
    logic [ADDRESS_WIDTH-1:0] wsync_bin;
    logic [ADDRESS_WIDTH-1:0] read_address_inc;
    logic                     load;

    logic [ADDRESS_WIDTH-1:0] read_address_q,      read_address_d;
    logic [ADDRESS_WIDTH-1:0] read_address_gray_q, read_address_gray_d;
    logic                     out_valid_q,         out_valid_d;
    logic [DATA_WIDTH-1:0]    out_data_q,          out_data_d;

    cdc_sync_bus #(
        .WIDTH  (ADDRESS_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clock (clock),
        .reset (reset),
        .d     (write_address_gray),
        .q     (wsync_gray)
    );

    // Decode synchronized write pointer and derive flags from registers only.
    always_comb begin
        wsync_bin        = ADDRESS_WIDTH'(gray2bin(32'(wsync_gray)));
        empty            = (read_address_q == wsync_bin);
        ram_count        = wsync_bin - read_address_q;
        read_address_inc = read_address_q + 1'b1;
        load             = !empty && (!out_valid_q || out_ready);
    end

    // Next-state: load refills the output register (also covers consume+load
    // in one edge); a consume without refill only drops out_valid.
    always_comb begin
        read_address_d      = read_address_q;
        read_address_gray_d = read_address_gray_q;
        out_valid_d         = out_valid_q;
        out_data_d          = out_data_q;
        if (load) begin
            out_data_d          = mem_read_data;
            out_valid_d         = 1'b1;
            read_address_d      = read_address_inc;
            read_address_gray_d = ADDRESS_WIDTH'(bin2gray(32'(read_address_inc)));
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Read-side state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_address_q      <= '0;
            read_address_gray_q <= '0;
            out_valid_q         <= 1'b0;
            out_data_q          <= '0;
        end else begin
            read_address_q      <= read_address_d;
            read_address_gray_q <= read_address_gray_d;
            out_valid_q         <= out_valid_d;
            out_data_q          <= out_data_d;
        end
    end

    assign read_address      = read_address_q;
    assign read_address_gray = read_address_gray_q;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;

endmodule

// File: tb/tb_cdc_fifo_read_state.sv
// Bench for cdc_fifo_read_state: directed vectors; words written into the
// model RAM are queued as expected output and a monitor pops/compares each
// accepted handshake.
module tb_cdc_fifo_read_state;

    logic       clock;
    logic       clk_en;
    logic       reset;
    logic [3:0] write_address_gray;
    logic [7:0] mem_read_data;
    logic [3:0] read_address;
    logic [3:0] read_address_gray;
    logic       empty;
    logic [3:0] ram_count;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    logic [7:0] ram [16];
    logic [3:0] wptr;
    logic [7:0] exp_q [$];
    int         checks;
    int         errors;

    cdc_fifo_read_state #(
        .ADDRESS_WIDTH (4),
        .DATA_WIDTH    (8),
        .SYNC_STAGES   (2)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .write_address_gray (write_address_gray),
        .mem_read_data      (mem_read_data),
        .read_address       (read_address),
        .read_address_gray  (read_address_gray),
        .empty              (empty),
        .ram_count          (ram_count),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data)
    );

    assign mem_read_data = ram[read_address];

    initial clock = 1'b0;
    always #5 if (clk_en) clock = ~clock;

    function automatic logic [3:0] tb_gray(input logic [3:0] b);
        return {b[3], b[3] ^ b[2], b[2] ^ b[1], b[1] ^ b[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Writer model: store word at write pointer, queue it, advance pointer.
    task automatic put(input logic [7:0] v);
        ram[wptr] = v;
        exp_q.push_back(v);
        wptr = wptr + 4'd1;
        write_address_gray = tb_gray(wptr);
    endtask

    // Monitor: each accepted handshake must deliver the next queued word.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: got 0x%0h expected no word", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL scoreboard_data: got 0x%0h expected 0x%0h", out_data, e);
                end
            end
        end
    end

    initial begin
        logic [3:0] exp_gray [4];
        logic [3:0] prev;
        int         idx;
        int         n;

        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        wptr = 4'd0;
        write_address_gray = 4'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;

        // 1. Reset with no clock running
        reset = 1'b1;
        #3;
        chk("rst_read_address", read_address, 0);
        chk("rst_read_gray", read_address_gray, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ram_count", ram_count, 0);
        #3;
        reset = 1'b0;
        #2;
        clk_en = 1'b1;

        // 2. Single word
        put(8'hA5);
        step();
        chk("t2_e1_empty", empty, 1);
        step();
        chk("t2_e2_empty", empty, 0);
        chk("t2_e2_count", ram_count, 1);
        chk("t2_e2_valid", out_valid, 0);
        step();
        chk("t2_e3_valid", out_valid, 1);
        chk("t2_e3_data", out_data, 8'hA5);
        chk("t2_e3_raddr", read_address, 1);
        chk("t2_e3_rgray", read_address_gray, 1);
        chk("t2_e3_empty", empty, 1);
        out_ready = 1'b1;
        step();
        chk("t2_consumed_valid", out_valid, 0);
        out_ready = 1'b0;

        // 3. Backpressure then streaming (read pointer starts at 1)
        put(8'h11);
        put(8'h22);
        put(8'h33);
        step();
        step();
        chk("t3_visible_count", ram_count, 3);
        chk("t3_visible_valid", out_valid, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_data", out_data, 8'h11);
            chk("t3_hold_raddr", read_address, 2);
            chk("t3_hold_count", ram_count, 2);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("t3_s1_data", out_data, 8'h22);
        chk("t3_s1_raddr", read_address, 3);
        step();
        chk("t3_s2_data", out_data, 8'h33);
        chk("t3_s2_raddr", read_address, 4);
        step();
        chk("t3_end_valid", out_valid, 0);
        chk("t3_end_raddr", read_address, 4);
        chk("t3_end_empty", empty, 1);

        // 4. Wrap-around: stream up to address 14, then read 14,15,0,1
        for (int i = 4; i < 14; i++) put(8'h50 + 8'(i));
        n = 0;
        while (!(read_address == 4'd14 && !out_valid) && n < 60) begin
            step();
            n++;
        end
        chk("t4_drain_raddr", read_address, 14);
        chk("t4_drain_valid", out_valid, 0);
        chk("t4_start_gray", read_address_gray, 4'b1001);
        exp_gray[0] = 4'b1000;
        exp_gray[1] = 4'b0000;
        exp_gray[2] = 4'b0001;
        exp_gray[3] = 4'b0011;
        prev = read_address_gray;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 4) put(8'hC0 + 8'(c));
            step();
            if (read_address_gray !== prev) begin
                chk("t4_gray_onebit", 32'($countones(read_address_gray ^ prev)), 1);
                if (idx < 4) chk("t4_gray_seq", read_address_gray, exp_gray[idx]);
                else chk("t4_gray_extra", idx, 4);
                idx++;
                prev = read_address_gray;
            end
        end
        chk("t4_gray_changes", idx, 4);
        chk("t4_end_empty", empty, 1);
        chk("t4_end_count", ram_count, 0);
        chk("t4_end_valid", out_valid, 0);
        chk("t4_queue_drained", exp_q.size(), 0);

        // 5. Full depth: 15 words in RAM, read pointer at 2
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) put(8'h40 + 8'(i));
        step();
        step();
        chk("t5_full_count", ram_count, 15);
        chk("t5_full_valid", out_valid, 0);
        step();
        chk("t5_load_count", ram_count, 14);
        chk("t5_load_valid", out_valid, 1);
        chk("t5_load_data", out_data, 8'h40);
        chk("t5_load_raddr", read_address, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_stall_raddr", read_address, 3);
            chk("t5_stall_count", ram_count, 14);
            chk("t5_stall_data", out_data, 8'h40);
        end

        // 6. Mid-stream reset
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("t6_streaming_valid", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_raddr", read_address, 0);
        chk("t6_rst_rgray", read_address_gray, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_count", ram_count, 0);
        exp_q.delete();
        wptr = 4'd0;
        write_address_gray = 4'd0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_post_valid", out_valid, 0);
            chk("t6_post_empty", empty, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
